core_lsu: RTL and testbench
===========================

# core_lsu

Load/store unit stage directly downstream of the execute stage. Accepts one memory request per instruction (effective address and store data already computed by execute), runs a single request/acknowledge transaction on the data bus, and writes extended load data back to the register file. It drives a hold flag to the control block while a transaction is outstanding, so the pipeline stalls until the access completes or times out.

## Interface
Parameters:
- TIMEOUT, 64, maximum number of BUSY cycles with `bus_req_out` high before the access is abandoned (legal range 2..256).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_in  in  1  execute stage presents a load/store this cycle.
- we_in  in  1  1 = store, 0 = load.
- func3_in  in  3  width code. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- addr_in  in  32  effective byte address.
- wdata_in  in  32  store data (rs2 value).
- rd_in  in  5  load destination register.
- bus_req_out  out  1  transaction request.
- bus_we_out  out  1  transaction is a write.
- bus_addr_out  out  32  word address, bits [1:0] forced to 00.
- bus_be_out  out  4  byte enables.
- bus_wdata_out  out  32  lane-replicated store data.
- bus_ack_in  in  1  completion strobe; `bus_rdata_in` is valid in the same cycle.
- bus_rdata_in  in  32  read word.
- hold_flag_out  out  1  stall request to control.
- reg_we_out  out  1  register write enable.
- reg_write_addr_out  out  5  register write address.
- reg_write_data_out  out  32  register write data.
- misalign_out  out  1  one-cycle pulse: request rejected.
- timeout_out  out  1  one-cycle pulse: access abandoned.

## Operation
- States: IDLE, BUSY, WB.
- Request acceptance (IDLE only):
  - A request is accepted when `req_in` is high, the request is legal, and it is aligned.
  - On acceptance, latch we, func3, addr, wdata and rd, clear the timeout counter, and go to BUSY.
  - `req_in` is ignored outside IDLE.
- Rejection:
  - Misaligned: H accesses with addr[0]=1, or W accesses with addr[1:0]≠00.
  - Illegal func3: load 011/11x, store 011/1xx.
  - A rejected request issues no bus access, pulses `misalign_out` on the next cycle, does not assert hold, and stays in IDLE.
- BUSY:
  - `bus_req_out`=1, and bus outputs come from latched values.
  - Ack, store: go to IDLE.
  - Ack, load: capture the extended data, then go to WB.
  - No ack: counter increments. If no ack arrives with counter = TIMEOUT−1, drop the request, pulse `timeout_out`, go to IDLE, and perform no register write.
  - Ack on the limit cycle counts as success.
- WB:
  - `reg_we_out` = 1 if latched rd ≠ 0.
  - `reg_write_addr_out` = rd, `reg_write_data_out` = captured word.
  - Next state is IDLE.
  - Outside WB, `reg_we_out`=0 and the write address and data are 0.
- Byte enables and write data (latched addr[1:0] = a):
  - SB: be = 0001 << a, wdata = {4{wdata[7:0]}}.
  - SH: be = a[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, wdata unchanged.
  - Loads drive be=1111 and wdata=0.
- Load extraction:
  - LB/LBU: select byte lane a.
  - LH/LHU: select halfword lane a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `hold_flag_out` is combinational: 1 when (IDLE and a request is accepted) or state is BUSY or WB.
- When `bus_req_out`=0, all bus outputs are 0.

## Timing
- Reset: state IDLE, counter 0, all latches 0, every output 0. Assertion mid-transaction drops `bus_req_out` immediately with no write or pulse. After release, IDLE.
- Acceptance at cycle 0 (hold=1 combinationally). `bus_req_out`=1 from cycle 1.
- Load with ack at cycle k: WB at cycle k+1, IDLE at k+2. Hold is high for cycles 0..k+1.
- Store with ack at cycle k: IDLE at k+1. Hold is high for cycles 0..k.
- Zero-wait bus (ack in cycle 1): load occupies 3 cycles, store 2.
- Timeout: `bus_req_out` high for exactly TIMEOUT cycles (1..TIMEOUT). `timeout_out` is high in cycle TIMEOUT+1, and state is IDLE then.
- Back-to-back: a new request can be accepted in the first IDLE cycle after WB or after store completion.
- An ack seen while in IDLE or WB is ignored.

## Test plan
- LW at addr 0x0000_1008, rd=5, ack in cycle 1 with rdata 0xDEAD_BEEF -> bus_addr 0x1008, be 1111; WB in cycle 2 writes x5=0xDEAD_BEEF; hold high in cycles 0–2.
- LB at 0x103 and LBU at 0x103 with rdata 0x80FF_0000 -> be 1111; LB writes 0xFFFF_FF80, LBU writes 0x0000_0080.
- SH at 0x2002, wdata 0x1234_ABCD, ack after 3 wait cycles -> be 1100, bus_wdata 0xABCD_ABCD, bus_req high for 4 cycles, no reg write.
- LW at 0x1001 -> no bus_req, no hold, misalign_out pulses 1 cycle; SB at 0x1001 -> accepted, be 0010.
- TIMEOUT=4, load with no ack -> bus_req high for 4 cycles, timeout_out pulses in cycle 5, reg_we never high; a subsequent LW completes normally.
- rst asserted during the BUSY of a load -> bus_req_out and hold drop asynchronously; no WB; after release, a fresh SW completes.

Source files
------------

// File: rtl/core_lsu.sv
// core_lsu: load/store stage between execute and the data bus.
// Runs one request/acknowledge bus transaction per accepted memory
// instruction and writes extended load data back to the register file.
module core_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [2:0]  func3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  output logic        hold_flag_out,
  output logic        reg_we_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] reg_write_data_out,
  output logic        misalign_out,
  output logic        timeout_out
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t      state, state_nxt;
  logic [8:0]  wait_cnt;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_rd;
  logic [31:0] load_q;
  logic        misalign_q;
  logic        timeout_q;

  logic        legal;
  logic        aligned;
  logic        accept;
  logic        reject;
  logic        at_limit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Classify the incoming request: legal width code, natural alignment, accept/reject.
  always_comb begin
    if (we_in) begin
      legal = (func3_in[2] == 1'b0) && (func3_in[1:0] != 2'b11);
    end else begin
      legal = (func3_in[1:0] != 2'b11) && !(func3_in[2] && func3_in[1]);
    end
    case (func3_in[1:0])
      2'b01:   aligned = !addr_in[0];
      2'b10:   aligned = (addr_in[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept   = (state == IDLE) && req_in && legal && aligned;
    reject   = (state == IDLE) && req_in && !(legal && aligned);
    at_limit = (wait_cnt == 9'(TIMEOUT - 1));
  end

  // Next-state logic; an ack on the limit cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: begin
        if (bus_ack_in) begin
          state_nxt = lat_we ? IDLE : WB;
        end else if (at_limit) begin
          state_nxt = IDLE;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latches, wait counter, captured load word and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_f3     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_rd     <= '0;
      load_q     <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      misalign_q <= reject;
      timeout_q  <= (state == BUSY) && !bus_ack_in && at_limit;
      if (accept) begin
        lat_we    <= we_in;
        lat_f3    <= func3_in;
        lat_addr  <= addr_in;
        lat_wdata <= wdata_in;
        lat_rd    <= rd_in;
        wait_cnt  <= '0;
      end else if (state == BUSY) begin
        if (bus_ack_in) begin
          if (!lat_we) load_q <= load_ext;
        end else if (!at_limit) begin
          wait_cnt <= wait_cnt + 9'd1;
        end
      end
    end
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    byte_sel = bus_rdata_in[7:0];
      2'd1:    byte_sel = bus_rdata_in[15:8];
      2'd2:    byte_sel = bus_rdata_in[23:16];
      default: byte_sel = bus_rdata_in[31:24];
    endcase
    half_sel = lat_addr[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];
    case (lat_f3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus_rdata_in;
    endcase
  end

  // Byte enables and lane-replicated store data; loads read the whole word.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = '0;
    if (lat_we) begin
      case (lat_f3[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << lat_addr[1:0];
          wdata_calc = {4{lat_wdata[7:0]}};
        end
        2'b01: begin
          be_calc    = lat_addr[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{lat_wdata[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = lat_wdata;
        end
      endcase
    end
  end

  // Output drive: bus fields only while requesting, register write only in WB.
  always_comb begin
    bus_req_out        = 1'b0;
    bus_we_out         = 1'b0;
    bus_addr_out       = '0;
    bus_be_out         = '0;
    bus_wdata_out      = '0;
    reg_we_out         = 1'b0;
    reg_write_addr_out = '0;
    reg_write_data_out = '0;
    if (state == BUSY) begin
      bus_req_out   = 1'b1;
      bus_we_out    = lat_we;
      bus_addr_out  = {lat_addr[31:2], 2'b00};
      bus_be_out    = be_calc;
      bus_wdata_out = wdata_calc;
    end
    if (state == WB) begin
      reg_we_out         = (lat_rd != 5'd0);
      reg_write_addr_out = lat_rd;
      reg_write_data_out = load_q;
    end
    hold_flag_out = accept || (state == BUSY) || (state == WB);
    misalign_out  = misalign_q;
    timeout_out   = timeout_q;
  end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed bench for core_lsu. Each transaction is expanded
// into a per-cycle timeline of expected outputs from the instruction-level
// rules, and every cycle is compared against the DUT.
module tb_core_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in, we_in;
  logic [2:0]  func3_in;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  rd_in;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_be_out;
  logic [31:0] bus_wdata_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;
  logic        hold_flag_out, reg_we_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] reg_write_data_out;
  logic        misalign_out, timeout_out;

  always #5 clk = ~clk;

  core_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .we_in(we_in), .func3_in(func3_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .rd_in(rd_in),
    .bus_req_out(bus_req_out), .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_be_out(bus_be_out), .bus_wdata_out(bus_wdata_out), .bus_ack_in(bus_ack_in),
    .bus_rdata_in(bus_rdata_in), .hold_flag_out(hold_flag_out), .reg_we_out(reg_we_out),
    .reg_write_addr_out(reg_write_addr_out), .reg_write_data_out(reg_write_data_out),
    .misalign_out(misalign_out), .timeout_out(timeout_out)
  );

  typedef struct {
    logic rst, req, we;
    logic [2:0] f3;
    logic [31:0] addr, wdata;
    logic [4:0] rd;
    logic ack;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    logic bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0] bus_be;
    logic [31:0] bus_wdata;
    logic hold, reg_we;
    logic [4:0] reg_addr;
    logic [31:0] reg_data;
    logic mis, to;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  int obs_req = 0, obs_hold = 0, obs_regwe = 0, obs_mis = 0, obs_to = 0;
  logic [31:0] obs_addr = '0, obs_bwdata = '0, obs_wb_data = '0;
  logic [3:0]  obs_be = '0;
  logic [4:0]  obs_wb_addr = '0;

  function automatic stim_t idle_s();
    stim_t s;
    s.rst = 0; s.req = 0; s.we = 0; s.f3 = '0; s.addr = '0; s.wdata = '0;
    s.rd = '0; s.ack = 0; s.rdata = '0;
    return s;
  endfunction

  function automatic exp_t zero_e();
    exp_t e;
    e.bus_req = 0; e.bus_we = 0; e.bus_addr = '0; e.bus_be = '0; e.bus_wdata = '0;
    e.hold = 0; e.reg_we = 0; e.reg_addr = '0; e.reg_data = '0; e.mis = 0; e.to = 0;
    return e;
  endfunction

  // Instruction-level model of the access rules.
  function automatic bit m_ok(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal, aligned;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    aligned = ((a % 4) % (1 << f3[1:0])) == 0;
    return legal && aligned;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [1:0] a);
    int nbytes;
    int first;
    logic [3:0] be;
    if (!we) return 4'hF;
    nbytes = 1 << f3[1:0];
    first  = (int'(a) / nbytes) * nbytes;
    be = '0;
    for (int i = 0; i < 4; i++) if (i >= first && i < first + nbytes) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic we, input logic [2:0] f3, input logic [31:0] d);
    if (!we) return 32'd0;
    if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Drive one cycle just after the rising edge, compare at the falling edge.
  task automatic apply_stimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.rst; req_in = s.req; we_in = s.we; func3_in = s.f3; addr_in = s.addr;
    wdata_in = s.wdata; rd_in = s.rd; bus_ack_in = s.ack; bus_rdata_in = s.rdata;
    @(negedge clk);
    check_output("bus_req",   32'(bus_req_out),        32'(e.bus_req));
    check_output("bus_we",    32'(bus_we_out),         32'(e.bus_we));
    check_output("bus_addr",  bus_addr_out,            e.bus_addr);
    check_output("bus_be",    32'(bus_be_out),         32'(e.bus_be));
    check_output("bus_wdata", bus_wdata_out,           e.bus_wdata);
    check_output("hold",      32'(hold_flag_out),      32'(e.hold));
    check_output("reg_we",    32'(reg_we_out),         32'(e.reg_we));
    check_output("reg_addr",  32'(reg_write_addr_out), 32'(e.reg_addr));
    check_output("reg_data",  reg_write_data_out,      e.reg_data);
    check_output("misalign",  32'(misalign_out),       32'(e.mis));
    check_output("timeout",   32'(timeout_out),        32'(e.to));
    if (bus_req_out) begin
      obs_req++; obs_addr = bus_addr_out; obs_be = bus_be_out; obs_bwdata = bus_wdata_out;
    end
    if (hold_flag_out) obs_hold++;
    if (reg_we_out) begin
      obs_regwe++; obs_wb_data = reg_write_data_out; obs_wb_addr = reg_write_addr_out;
    end
    if (misalign_out) obs_mis++;
    if (timeout_out) obs_to++;
  endtask

  // One full instruction: acceptance/rejection, bus phase, optional write-back.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata, input bit no_ack);
    stim_t s;
    exp_t  e, eb;
    int    nb;
    bit    ok;
    ok = m_ok(we, f3, addr);
    s = idle_s();
    s.req = 1; s.we = we; s.f3 = f3; s.addr = addr; s.wdata = wd; s.rd = rd;
    e = zero_e();
    e.hold = ok;
    apply_stimulus(s, e);
    if (!ok) begin
      e = zero_e();
      e.mis = 1;
      apply_stimulus(idle_s(), e);
      return;
    end
    eb = zero_e();
    eb.bus_req = 1; eb.bus_we = we; eb.bus_addr = addr & 32'hFFFF_FFFC;
    eb.bus_be = m_be(we, f3, addr[1:0]); eb.bus_wdata = m_wd(we, f3, wd); eb.hold = 1;
    nb = no_ack ? TO : waits + 1;
    for (int i = 1; i <= nb; i++) begin
      s = idle_s();
      s.req = 1; s.we = ~we; s.f3 = 3'd2; s.addr = 32'(i * 4); s.rd = 5'd9;
      s.ack = !no_ack && (i == nb);
      s.rdata = s.ack ? rdata : (32'hBAD0_0000 | 32'(i));
      apply_stimulus(s, eb);
    end
    if (no_ack) begin
      e = zero_e();
      e.to = 1;
      apply_stimulus(idle_s(), e);
    end else if (!we) begin
      s = idle_s();
      s.ack = 1; s.rdata = 32'h5A5A_5A5A;
      e = zero_e();
      e.hold = 1; e.reg_we = (rd != 5'd0); e.reg_addr = rd;
      e.reg_data = m_ext(f3, addr[1:0], rdata);
      apply_stimulus(s, e);
    end
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    int r0, h0, w0, m0, t0;

    rst = 1; req_in = 0; we_in = 0; func3_in = '0; addr_in = '0; wdata_in = '0;
    rd_in = '0; bus_ack_in = 0; bus_rdata_in = '0;

    s = idle_s(); s.rst = 1;
    apply_stimulus(s, zero_e());
    apply_stimulus(s, zero_e());
    apply_stimulus(idle_s(), zero_e());

    // LW zero-wait
    r0 = obs_req; h0 = obs_hold;
    run_txn(1'b0, 3'b010, 32'h0000_1008, 32'h0, 5'd5, 0, 32'hDEAD_BEEF, 1'b0);
    check_output("lw_addr_lit", obs_addr, 32'h0000_1008);
    check_output("lw_be_lit", 32'(obs_be), 32'hF);
    check_output("lw_data_lit", obs_wb_data, 32'hDEAD_BEEF);
    check_output("lw_rd_lit", 32'(obs_wb_addr), 32'd5);
    check_output("lw_hold_cycles", 32'(obs_hold - h0), 32'd3);
    check_output("lw_req_cycles", 32'(obs_req - r0), 32'd1);

    // LB / LBU on the top lane, back-to-back
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h80FF_0000, 1'b0);
    check_output("lb_lit", obs_wb_data, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h80FF_0000, 1'b0);
    check_output("lbu_lit", obs_wb_data, 32'h0000_0080);

    // LH / LHU upper halfword
    run_txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 5'd3, 0, 32'h8001_7FFF, 1'b0);
    check_output("lh_lit", obs_wb_data, 32'hFFFF_8001);
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 5'd3, 2, 32'h8001_7FFF, 1'b0);
    check_output("lhu_lit", obs_wb_data, 32'h0000_8001);

    // SH with 3 wait states
    r0 = obs_req; w0 = obs_regwe;
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 3, 32'h0, 1'b0);
    check_output("sh_be_lit", 32'(obs_be), 32'hC);
    check_output("sh_wdata_lit", obs_bwdata, 32'hABCD_ABCD);
    check_output("sh_req_cycles", 32'(obs_req - r0), 32'd4);
    check_output("sh_no_regwe", 32'(obs_regwe - w0), 32'd0);

    // Misaligned LW, then SB at the same address
    r0 = obs_req; h0 = obs_hold; m0 = obs_mis;
    run_txn(1'b0, 3'b010, 32'h0000_1001, 32'h0, 5'd4, 0, 32'h0, 1'b0);
    check_output("mis_req", 32'(obs_req - r0), 32'd0);
    check_output("mis_hold", 32'(obs_hold - h0), 32'd0);
    check_output("mis_pulse", 32'(obs_mis - m0), 32'd1);
    run_txn(1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 5'd0, 0, 32'h0, 1'b0);
    check_output("sb_be_lit", 32'(obs_be), 32'h2);

    // Illegal width codes and further misalignment
    run_txn(1'b1, 3'b100, 32'h0000_0000, 32'h1, 5'd1, 0, 32'h0, 1'b0);
    run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h1, 5'd1, 0, 32'h0, 1'b0);
    run_txn(1'b0, 3'b110, 32'h0000_0000, 32'h1, 5'd1, 0, 32'h0, 1'b0);
    run_txn(1'b1, 3'b001, 32'h0000_0003, 32'h1, 5'd1, 0, 32'h0, 1'b0);
    run_txn(1'b1, 3'b010, 32'h0000_0002, 32'h1, 5'd1, 0, 32'h0, 1'b0);

    // SB on every lane, SW, load to x0
    for (int a = 0; a < 4; a++)
      run_txn(1'b1, 3'b000, 32'h0000_4000 + 32'(a), 32'hCAFE_F00D, 5'd0, a, 32'h0, 1'b0);
    run_txn(1'b1, 3'b010, 32'h0000_5004, 32'h0102_0304, 5'd0, 1, 32'h0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd0, 0, 32'h1111_2222, 1'b0);

    // Ack on the limit cycle succeeds
    run_txn(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd12, TO - 1, 32'h7777_8888, 1'b0);
    check_output("limit_ack_lit", obs_wb_data, 32'h7777_8888);

    // Timeout, then a normal LW
    r0 = obs_req; w0 = obs_regwe; t0 = obs_to;
    run_txn(1'b0, 3'b010, 32'h0000_8000, 32'h0, 5'd6, 0, 32'h0, 1'b1);
    check_output("to_req_cycles", 32'(obs_req - r0), 32'd4);
    check_output("to_pulse", 32'(obs_to - t0), 32'd1);
    check_output("to_no_regwe", 32'(obs_regwe - w0), 32'd0);
    run_txn(1'b0, 3'b010, 32'h0000_8004, 32'h0, 5'd6, 0, 32'h0BAD_F00D, 1'b0);
    check_output("after_to_lit", obs_wb_data, 32'h0BAD_F00D);

    // Ack while idle is ignored
    s = idle_s(); s.ack = 1; s.rdata = 32'hFFFF_FFFF;
    apply_stimulus(s, zero_e());

    // Reset during the bus phase of a load
    w0 = obs_regwe;
    s = idle_s(); s.req = 1; s.f3 = 3'b010; s.addr = 32'h0000_9000; s.rd = 5'd8;
    e = zero_e(); e.hold = 1;
    apply_stimulus(s, e);
    e = zero_e(); e.bus_req = 1; e.bus_addr = 32'h0000_9000; e.bus_be = 4'hF; e.hold = 1;
    apply_stimulus(idle_s(), e);
    s = idle_s(); s.rst = 1;
    apply_stimulus(s, zero_e());
    apply_stimulus(idle_s(), zero_e());
    apply_stimulus(idle_s(), zero_e());
    check_output("rst_no_regwe", 32'(obs_regwe - w0), 32'd0);
    r0 = obs_req;
    run_txn(1'b1, 3'b010, 32'h0000_A008, 32'h55AA_33CC, 5'd0, 1, 32'h0, 1'b0);
    check_output("rst_sw_wdata_lit", obs_bwdata, 32'h55AA_33CC);
    check_output("rst_sw_req_cycles", 32'(obs_req - r0), 32'd2);
    apply_stimulus(idle_s(), zero_e());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
